uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver. It is the successor to the fixed 8N1 receiver in the serial subsystem. It takes the same oversampling tick from the shared baud generator and adds:
- configurable data width, parity and stop-bit count;
- a 2-flop input synchroniser and 3-sample majority vote;
- a valid/ready output handshake with a one-entry holding register;
- distinct frame, parity and overrun error pulses.

It sits between the pad-side `rx_in` line and the bus-side RX register/FIFO.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9; sent LSB first.
- OVERSAMPLE, 16: sample ticks per bit, even, legal 8..32.
- PARITY_EN, 0: 1 = a parity bit follows the data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- sample_tick  in  1  one-clk pulse at OVERSAMPLE × baud.
- rx_in  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  received word; stable while data_valid=1.
- data_valid  out  1  holding register full.
- data_ready  in  1  consumer accepts data when data_valid & data_ready.
- parity_err  out  1  one-clk pulse: frame delivered, parity mismatch.
- frame_err  out  1  one-clk pulse: a stop bit sampled low; frame discarded.
- overrun  out  1  one-clk pulse: good frame completed while the holding register was full and not being drained; frame discarded.
- busy  out  1  FSM not in IDLE.

## Operation
- Synchroniser: 2 flops on rx_in, both reset to 1, clocked every clk. `rx_s` is the second flop.
- Vote register: 3-bit shift of `rx_s`, updated only on sample_tick, reset 3'b111. `vote` = majority of the 3 bits.
- Tick counter `cnt`: width clog2(OVERSAMPLE), advances only on sample_tick. Bit counter: 0..DATA_BITS-1. Stop counter: 0..STOP_BITS-1.
- FSM states and transitions:
  - IDLE: on a tick with `rx_s`=0 → START, cnt=0.
  - START: on the tick where cnt==OVERSAMPLE/2-1, check `rx_s`:
    - if 1, the start was a glitch → IDLE, with no error.
    - if 0 → DATA, cnt=0, bit counter=0.
  - DATA: on the tick where cnt==OVERSAMPLE-1, shift `vote` into the MSB of the shift register (right shift, so LSB first), cnt=0, increment the bit counter. After the bit with index DATA_BITS-1 → PARITY if PARITY_EN, else STOP.
  - PARITY: on cnt==OVERSAMPLE-1, latch `vote` as the parity bit → STOP.
    - Even parity: XOR of data bits and parity bit must be 0. Odd parity: it must be 1.
  - STOP: on each cnt==OVERSAMPLE-1, check `vote`.
    - If 0: frame_err pulses and the FSM → IDLE immediately; the frame is discarded.
    - If 1 on the last stop bit: complete the frame (below) → IDLE.
- Frame completion:
  - If the holding register is empty, or draining this clk (valid & ready): load data_out, set data_valid, and pulse parity_err if parity mismatched.
  - Otherwise: pulse overrun, keep the old data, drop the new frame, and do not pulse parity_err.
- Handshake: data_valid clears on the clk where data_valid & data_ready, unless a completion reloads it in that same clk, in which case it stays 1 with the new data.
- With no sample_tick, all state holds; only the synchroniser moves.

## Timing
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. The FSM goes to IDLE and all counters and shift registers go to 0, except the synchroniser and vote register, which go to 1s.
- reset_n asserting mid-frame aborts the frame with no error pulse. After reset_n deasserts, the receiver waits for a fresh falling edge.
- All outputs are registered. Error pulses are exactly 1 clk wide, in the clk after the deciding tick.
- data_valid rises in the clk after the final stop-bit tick.
- Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) × OVERSAMPLE ticks, ±1 tick of start-edge detection, plus 2 clk of synchroniser latency.
- The receiver can accept back-to-back frames: the next start edge is recognised on the first tick after returning to IDLE.

## Test plan
- Default parameters, OVERSAMPLE=16, frame 0xA5 → data_valid=1, data_out=0xA5. It holds until data_ready=1, then drops the next clk.
- PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7, frame 0x41 sent with parity bit 1 → data_out=0x41 with a single-clk parity_err pulse. The same frame with parity bit 0 → no error pulse.
- STOP_BITS=2, second stop bit driven low → frame_err for 1 clk, data_valid stays 0, the next frame 0x3C is received correctly.
- 1-tick low glitch on an idle line, then a 1-tick low spike mid-bit in frame 0xFF → no frame from the glitch, and 0xFF is received thanks to the majority vote.
- Two back-to-back frames 0x11, 0x22 with data_ready=0 → data_out=0x11 and overrun pulses once. Repeat with data_ready pulsed on the clk the second frame completes → data_out=0x22, no overrun.
- reset_n pulsed low during DATA of frame 0x5A → all outputs 0, busy=0, no error pulse. The next frame 0x5A is received intact.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start detection, 3-sample majority vote,
// optional parity, 1-2 stop bits and a one-entry valid/ready holding register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   rx_s_q, rx_s_d;
    logic [2:0]             vote_q, vote_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic vote;
    logic parity_bad;

    assign vote       = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    assign parity_bad = (PARITY_EN != 0) && ((^shift_q ^ par_bit_q) != (PARITY_ODD != 0));

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        sync1_d      = rx_in;
        rx_s_d       = sync1_q;
        vote_d       = vote_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q & ~data_ready;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (sample_tick) begin
            vote_d = {vote_q[1:0], rx_s_q};
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            cnt_d     = '0;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                        cnt_d     = '0;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        par_bit_d  = vote;
                        cnt_d      = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!vote) begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end else if (stop_cnt_q == STOP_LAST) begin
                            state_d = S_IDLE;
                            // A draining holding register can take the new word in the same clk.
                            if (!data_valid_q || data_ready) begin
                                data_out_d   = shift_q;
                                data_valid_d = 1'b1;
                                parity_err_d = parity_bad;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            stop_cnt_d = stop_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            vote_q       <= 3'b111;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            vote_q       <= vote_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 7E1, 8N2) share clock, tick and reset;
// delivered words are scored against a queue, error pulses are counted per instance.
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx [3];
    logic       rdy [3];
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic       dv [3];
    logic       perr [3];
    logic       ferr [3];
    logic       ovr [3];
    logic       bsy [3];

    int checks = 0;
    int errors = 0;
    int perr_cnt [3];
    int ferr_cnt [3];
    int ovr_cnt [3];

    typedef struct {
        int         inst;
        logic [8:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
        logic [1:0] stop;
        logic       deliver;
        int         perr;
        int         ferr;
    } vec_t;
    vec_t vecs [12];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS)) u0 (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .rx_in(rx[0]),
        .data_out(d0), .data_valid(dv[0]), .data_ready(rdy[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0])
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .rx_in(rx[1]),
        .data_out(d1), .data_valid(dv[1]), .data_ready(rdy[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1])
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(2)) u2 (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .rx_in(rx[2]),
        .data_out(d2), .data_valid(dv[2]), .data_ready(rdy[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2])
    );

    always #5 clk = ~clk;

    // One tick every 4 clks, changed 1 time unit after the edge.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] get_dout(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {2'b00, d1};
            default: return {1'b0, d2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (perr[i]) perr_cnt[i]++;
            if (ferr[i]) ferr_cnt[i]++;
            if (ovr[i])  ovr_cnt[i]++;
            if (dv[i] && rdy[i]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: inst %0d delivered %0h with nothing expected", i, get_dout(i));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_inst", 32'(i), 32'(e.inst));
                    check("sb_data", 32'(get_dout(i)), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!sample_tick);
        #2;
    endtask

    task automatic idle_ticks(input int inst, input int n);
        rx[inst] = 1'b1;
        repeat (n) wait_tick();
    endtask

    // Sends one frame; optional 1-tick low spike at the sample point of bit spike_bit,
    // optional 1-clk data_ready pulse on the clk that completes the frame.
    task automatic send_frame(input int inst, input logic [8:0] data, input logic par,
                              input logic [1:0] stop, input int spike_bit, input logic ready_pulse);
        int   nbits;
        int   pen;
        int   nb;
        logic b;
        nbits = (inst == 1) ? 7 : 8;
        pen   = (inst == 1) ? 1 : 0;
        nb    = 1 + nbits + pen + ((inst == 2) ? 2 : 1);
        for (int k = 0; k < nb; k++) begin
            if (k == 0)                         b = 1'b0;
            else if (k <= nbits)                b = data[k-1];
            else if (pen == 1 && k == nbits+1)  b = par;
            else                                b = stop[k-1-nbits-pen];
            rx[inst] = b;
            for (int t = 0; t < OS; t++) begin
                if (k == spike_bit && t == 8) rx[inst] = 1'b0;
                if (k == spike_bit && t == 9) rx[inst] = b;
                if (ready_pulse && k == nb-1 && t == 8) begin
                    do begin @(posedge clk); #2; end while (!sample_tick);
                    rdy[inst] = 1'b1;
                    wait_tick();
                    rdy[inst] = 1'b0;
                end else begin
                    wait_tick();
                end
            end
        end
    endtask

    initial begin
        int p0, f0, o0;
        exp_t e;

        vecs[0]  = '{0, 9'h03C, 1'b0, 2'b11, 1'b1, 0, 0};
        vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, 1'b1, 0, 0};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 1'b1, 0, 0};
        vecs[3]  = '{0, 9'h055, 1'b0, 2'b00, 1'b0, 0, 1};
        vecs[4]  = '{1, 9'h041, 1'b1, 2'b11, 1'b1, 1, 0};
        vecs[5]  = '{1, 9'h041, 1'b0, 2'b11, 1'b1, 0, 0};
        vecs[6]  = '{1, 9'h07F, 1'b1, 2'b11, 1'b1, 0, 0};
        vecs[7]  = '{1, 9'h07F, 1'b0, 2'b11, 1'b1, 1, 0};
        vecs[8]  = '{2, 9'h03C, 1'b0, 2'b11, 1'b1, 0, 0};
        vecs[9]  = '{2, 9'h0C3, 1'b0, 2'b01, 1'b0, 0, 1};
        vecs[10] = '{2, 9'h03C, 1'b0, 2'b11, 1'b1, 0, 0};
        vecs[11] = '{2, 9'h081, 1'b0, 2'b10, 1'b0, 0, 1};

        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1;
            rdy[i] = 1'b0;
            perr_cnt[i] = 0;
            ferr_cnt[i] = 0;
            ovr_cnt[i] = 0;
        end

        repeat (4) @(posedge clk);
        #2;
        check("rst_valid", 32'(dv[0]), 0);
        check("rst_data",  32'(get_dout(0)), 0);
        check("rst_busy",  32'(bsy[0]), 0);
        check("rst_errs",  32'({perr[0], ferr[0], ovr[0]}), 0);
        reset_n = 1'b1;
        idle_ticks(0, 4);

        // Held word stays until accepted, then drops the next clk.
        send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b0);
        idle_ticks(0, 4);
        check("hold_valid", 32'(dv[0]), 1);
        check("hold_data",  32'(get_dout(0)), 32'h0A5);
        repeat (10) @(posedge clk);
        #2;
        check("hold_still", 32'(dv[0]), 1);
        e.inst = 0; e.data = 9'h0A5; exp_q.push_back(e);
        rdy[0] = 1'b1;
        @(posedge clk);
        #2 rdy[0] = 1'b0;
        check("hold_drop", 32'(dv[0]), 0);

        for (int v = 0; v < 12; v++) begin
            rdy[vecs[v].inst] = 1'b1;
            p0 = perr_cnt[vecs[v].inst];
            f0 = ferr_cnt[vecs[v].inst];
            o0 = ovr_cnt[vecs[v].inst];
            if (vecs[v].deliver) begin
                e.inst = vecs[v].inst; e.data = vecs[v].data; exp_q.push_back(e);
            end
            send_frame(vecs[v].inst, vecs[v].data, vecs[v].par, vecs[v].stop, -1, 1'b0);
            idle_ticks(vecs[v].inst, 24);
            check($sformatf("vec%0d_perr", v), 32'(perr_cnt[vecs[v].inst] - p0), 32'(vecs[v].perr));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt[vecs[v].inst] - f0), 32'(vecs[v].ferr));
            check($sformatf("vec%0d_ovr", v),  32'(ovr_cnt[vecs[v].inst] - o0), 0);
            check($sformatf("vec%0d_sb", v),   32'(exp_q.size()), 0);
            check($sformatf("vec%0d_busy", v), 32'(bsy[vecs[v].inst]), 0);
            rdy[vecs[v].inst] = 1'b0;
        end

        // Idle-line glitch, then a mid-bit spike masked by the vote.
        rdy[0] = 1'b1;
        f0 = ferr_cnt[0];
        rx[0] = 1'b0;
        wait_tick();
        idle_ticks(0, 20);
        check("glitch_busy", 32'(bsy[0]), 0);
        check("glitch_none", 32'(exp_q.size()), 0);
        e.inst = 0; e.data = 9'h0FF; exp_q.push_back(e);
        send_frame(0, 9'h0FF, 1'b0, 2'b11, 3, 1'b0);
        idle_ticks(0, 24);
        check("spike_sb",   32'(exp_q.size()), 0);
        check("spike_ferr", 32'(ferr_cnt[0] - f0), 0);

        // Back-to-back frames with no consumer: second frame overruns.
        rdy[0] = 1'b0;
        o0 = ovr_cnt[0];
        p0 = perr_cnt[0];
        send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0);
        idle_ticks(0, 8);
        check("ovr_count", 32'(ovr_cnt[0] - o0), 1);
        check("ovr_perr",  32'(perr_cnt[0] - p0), 0);
        check("ovr_valid", 32'(dv[0]), 1);
        check("ovr_data",  32'(get_dout(0)), 32'h011);
        e.inst = 0; e.data = 9'h011; exp_q.push_back(e);
        rdy[0] = 1'b1;
        idle_ticks(0, 4);
        check("ovr_sb", 32'(exp_q.size()), 0);
        rdy[0] = 1'b0;

        // Drain on the completing clk: new word replaces old, no overrun.
        o0 = ovr_cnt[0];
        e.inst = 0; e.data = 9'h011; exp_q.push_back(e);
        e.inst = 0; e.data = 9'h022; exp_q.push_back(e);
        send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b1);
        idle_ticks(0, 4);
        check("drain_ovr",   32'(ovr_cnt[0] - o0), 0);
        check("drain_valid", 32'(dv[0]), 1);
        check("drain_data",  32'(get_dout(0)), 32'h022);
        rdy[0] = 1'b1;
        idle_ticks(0, 4);
        check("drain_sb", 32'(exp_q.size()), 0);

        // Reset mid-frame with a word held: everything clears, no pulses.
        rdy[0] = 1'b0;
        send_frame(0, 9'h096, 1'b0, 2'b11, -1, 1'b0);
        idle_ticks(0, 4);
        check("pre_rst_valid", 32'(dv[0]), 1);
        p0 = perr_cnt[0]; f0 = ferr_cnt[0]; o0 = ovr_cnt[0];
        rx[0] = 1'b0;
        repeat (OS) wait_tick();
        for (int k = 0; k < 3; k++) begin
            rx[0] = k[0] ? 1'b1 : 1'b0;
            repeat (OS) wait_tick();
        end
        check("pre_rst_busy", 32'(bsy[0]), 1);
        rx[0] = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(dv[0]), 0);
        check("mid_rst_data",  32'(get_dout(0)), 0);
        check("mid_rst_busy",  32'(bsy[0]), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle_ticks(0, 20);
        check("post_rst_busy", 32'(bsy[0]), 0);
        check("post_rst_pulses", 32'((perr_cnt[0] - p0) + (ferr_cnt[0] - f0) + (ovr_cnt[0] - o0)), 0);
        rdy[0] = 1'b1;
        e.inst = 0; e.data = 9'h05A; exp_q.push_back(e);
        send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 1'b0);
        idle_ticks(0, 8);
        check("post_rst_sb", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
